// File: rtl/arb_muxn.sv
// N-channel arbitrated multiplexer with a single registered output slot.
// Defining ARB_MUXN_RR_EN selects round-robin arbitration; otherwise fixed lowest-index priority.
`timescale 1ns/1ps

module arb_muxn #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_sel_q;

  logic [NCH-1:0]   grant;
  logic [SELW-1:0]  gidx;
  logic             found;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

`ifdef ARB_MUXN_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;
  int unsigned     idx;

  // Scan upward from ptr, wrapping past NCH-1 back to channel 0.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      if (!found && in_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = SELW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gidx == SELW'(NCH - 1)) ? '0 : gidx + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && in_valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gidx     = SELW'(i);
      end
    end
  end
`endif

  // The slot may accept a new item when empty or when it is draining this cycle.
  assign load_en  = ~out_valid_q | out_ready;
  assign in_ready = resetn ? (grant & {NCH{load_en}}) : '0;
  assign xfer     = |in_ready;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_sel_q   <= gidx;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
